// File: rtl/fir_sekwenser_if.sv
// rtl/fir_sekwenser_if.sv - control/status, memory address and MAC strobe bundle of the FIR sequencer
interface fir_sekwenser_if #(
  parameter int W_PROBEK = 14,
  parameter int W_WSP    = 6
);
  logic                Start;
  logic [W_WSP-1:0]    Ile_wsp;
  logic [W_PROBEK-1:0] Ile_probek;
  logic                Pracuje;
  logic                DONE;
  logic [W_PROBEK-1:0] adr_probki;
  logic [W_WSP-1:0]    adr_wsp;
  logic                zero_probka;
  logic                mac_en;
  logic                mac_first;
  logic                wr_wyn;
  logic [W_PROBEK-1:0] adr_wyn;

  modport master (
    input  Start, Ile_wsp, Ile_probek,
    output Pracuje, DONE, adr_probki, adr_wsp, zero_probka,
           mac_en, mac_first, wr_wyn, adr_wyn
  );

  modport slave (
    output Start, Ile_wsp, Ile_probek,
    input  Pracuje, DONE, adr_probki, adr_wsp, zero_probka,
           mac_en, mac_first, wr_wyn, adr_wyn
  );
endinterface

// File: rtl/fir_sekwenser.sv
// rtl/fir_sekwenser.sv - FIR control sequencer: walks taps per output sample, aligns MAC strobes, writes results
module fir_sekwenser #(
  parameter int LAT      = 2,
  parameter int W_PROBEK = 14,
  parameter int W_WSP    = 6
) (
  input  logic           clk_b,
  input  logic           rst_n,
  fir_sekwenser_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FINISH} state_t;

  state_t              state_q;
  logic                start_q;
  logic [W_WSP-1:0]    n_wsp_q;
  logic [W_PROBEK-1:0] p_q;
  logic [W_PROBEK-1:0] n_q;
  logic [W_WSP-1:0]    k_q;
  logic [2:0]          drain_q;
  logic [LAT-1:0]      vld_dly_q;
  logic [LAT-1:0]      first_dly_q;
  logic                pracuje_q;
  logic                done_q;
  logic                zero_q;
  logic                wr_q;
  logic [W_PROBEK-1:0] adr_probki_q;
  logic [W_WSP-1:0]    adr_wsp_q;
  logic [W_PROBEK-1:0] adr_wyn_q;

  logic                start_evt;
  logic                issue_now;
  logic                first_now;
  logic                last_tap;
  logic                last_smp;
  logic [W_PROBEK-1:0] tap_n_d;
  logic [W_WSP-1:0]    tap_k_d;
  logic [W_PROBEK:0]   diff_d;

  assign start_evt = bus.Start & ~start_q;
  assign issue_now = (state_q == ISSUE);
  assign first_now = issue_now && (k_q == '0);
  assign last_tap  = (k_q == n_wsp_q - W_WSP'(1));
  assign last_smp  = (n_q == p_q - W_PROBEK'(1));

  // Address of the tap that will be presented in the next ISSUE cycle
  always_comb begin
    tap_n_d = n_q;
    tap_k_d = k_q + W_WSP'(1);
    if (state_q == WRITE) begin
      tap_n_d = n_q + W_PROBEK'(1);
      tap_k_d = '0;
    end else if (state_q == IDLE) begin
      tap_n_d = '0;
      tap_k_d = '0;
    end
    diff_d = {1'b0, tap_n_d} - {{(W_PROBEK + 1 - W_WSP){1'b0}}, tap_k_d};
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      n_wsp_q      <= '0;
      p_q          <= '0;
      n_q          <= '0;
      k_q          <= '0;
      drain_q      <= '0;
      vld_dly_q    <= '0;
      first_dly_q  <= '0;
      pracuje_q    <= 1'b0;
      done_q       <= 1'b0;
      zero_q       <= 1'b0;
      wr_q         <= 1'b0;
      adr_probki_q <= '0;
      adr_wsp_q    <= '0;
      adr_wyn_q    <= '0;
    end else begin
      start_q     <= bus.Start;
      vld_dly_q   <= (vld_dly_q << 1) | LAT'(issue_now);
      first_dly_q <= (first_dly_q << 1) | LAT'(first_now);
      wr_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_evt) begin
            n_wsp_q   <= bus.Ile_wsp;
            p_q       <= bus.Ile_probek;
            n_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            pracuje_q <= 1'b1;
            if (bus.Ile_wsp != '0 && bus.Ile_probek != '0) begin
              state_q      <= ISSUE;
              adr_wsp_q    <= tap_k_d;
              zero_q       <= diff_d[W_PROBEK];
              adr_probki_q <= diff_d[W_PROBEK] ? '0 : diff_d[W_PROBEK-1:0];
            end else begin
              state_q <= FINISH;
            end
          end
        end
        ISSUE: begin
          if (last_tap) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end else begin
            k_q          <= tap_k_d;
            adr_wsp_q    <= tap_k_d;
            zero_q       <= diff_d[W_PROBEK];
            adr_probki_q <= diff_d[W_PROBEK] ? '0 : diff_d[W_PROBEK-1:0];
          end
        end
        DRAIN: begin
          // Last tap reaches the MAC in the final DRAIN cycle, so the write sees a finished sum
          if (drain_q == 3'(LAT - 1)) begin
            state_q   <= WRITE;
            wr_q      <= 1'b1;
            adr_wyn_q <= n_q;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        WRITE: begin
          if (last_smp) begin
            state_q <= FINISH;
          end else begin
            state_q      <= ISSUE;
            n_q          <= tap_n_d;
            k_q          <= '0;
            adr_wsp_q    <= tap_k_d;
            zero_q       <= diff_d[W_PROBEK];
            adr_probki_q <= diff_d[W_PROBEK] ? '0 : diff_d[W_PROBEK-1:0];
          end
        end
        FINISH: begin
          state_q   <= IDLE;
          pracuje_q <= 1'b0;
          done_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Pracuje     = pracuje_q;
  assign bus.DONE        = done_q;
  assign bus.adr_probki  = adr_probki_q;
  assign bus.adr_wsp     = adr_wsp_q;
  assign bus.zero_probka = zero_q;
  assign bus.mac_en      = vld_dly_q[LAT-1];
  assign bus.mac_first   = first_dly_q[LAT-1];
  assign bus.wr_wyn      = wr_q;
  assign bus.adr_wyn     = adr_wyn_q;

endmodule

// File: doc/fir_sekwenser.md
Name: fir_sekwenser

Overview:
- Control sequencer directly downstream of the control-register block.
- Consumes Start, Ile_wsp and Ile_probek; returns the Pracuje and DONE status to the registers.
- Drives sample/coefficient memory read addresses, MAC enables and result-memory writes, one output sample at a time.
- Computes y[n] = sum over k = 0..Ile_wsp-1 of h[k]*x[n-k], for n = 0..Ile_probek-1, with x[negative index] treated as zero.

Parameters:
- LAT, 2: cycles from address issue to the data being valid at the MAC (memory read plus input register). Legal range 1..7.
- W_PROBEK, 14: sample address width; must equal the Ile_probek width.
- W_WSP, 6: coefficient address width; must equal the Ile_wsp width.

Ports:
- clk_b  in  1  system clock. Single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  start request level from the control registers.
- Ile_wsp  in  W_WSP  number of coefficients N.
- Ile_probek  in  W_PROBEK  number of samples P.
- Pracuje  out  1  busy flag.
- DONE  out  1  completion flag, sticky.
- adr_probki  out  W_PROBEK  sample memory read address.
- adr_wsp  out  W_WSP  coefficient memory read address.
- zero_probka  out  1  this tap uses x = 0; MAC input is forced to 0.
- mac_en  out  1  accumulate the tap arriving this cycle.
- mac_first  out  1  with mac_en: load the product instead of accumulating.
- wr_wyn  out  1  one-cycle result write strobe.
- adr_wyn  out  W_PROBEK  result memory write address.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs, counters, delay lines and the Start edge register are 0.

Start detection:
- Start_d is a registered copy of Start.
- start_evt = Start & ~Start_d, acted on only in IDLE.
- A rising edge while not in IDLE is ignored. A falling edge at any time is ignored.

On start_evt:
- Ile_wsp is latched to N_r and Ile_probek to P_r. Later input changes have no effect until the next start.
- DONE is cleared and Pracuje is set on the same clock edge.

FSM states: IDLE, ISSUE, DRAIN, WRITE, FINISH.
- IDLE → ISSUE on start_evt with N != 0 and P != 0.
- IDLE → FINISH on start_evt with N == 0 or P == 0. No memory or MAC activity occurs in this case.
- ISSUE: one tap per cycle, k from 0 to N_r-1, at sample n.
  - adr_wsp = k.
  - If n >= k: adr_probki = n-k, zero_probka = 0. Otherwise adr_probki = 0, zero_probka = 1.
  - After k = N_r-1 → DRAIN.
- DRAIN: lasts LAT cycles, then → WRITE.
- WRITE: wr_wyn = 1 and adr_wyn = n for exactly one cycle.
  - If n == P_r-1 → FINISH. Otherwise n increments, k resets to 0, → ISSUE.
- FINISH: one cycle. Pracuje is cleared and DONE is set on the transition to IDLE.
- adr_probki, adr_wsp and zero_probka are registered and valid during ISSUE cycles. They hold their last values elsewhere.

MAC alignment:
- mac_en is the ISSUE-valid bit delayed by exactly LAT cycles.
- mac_first is the (k == 0) bit delayed by exactly LAT cycles.
- The last mac_en of sample n occurs in the final DRAIN cycle. wr_wyn follows on the next cycle, so the accumulator is final when written.

Timing:
- Cycles per sample = N + LAT + 1.
- Pracuje rises 1 cycle after Start rises (the Start_d edge).
- Pracuje is high for 1 + P*(N+LAT+1) cycles, counting the FINISH cycle.
- DONE stays high until the next accepted start_evt or reset.

Status flags:
- Pracuje and DONE are never high together.
- Exception: both are 0 after reset and during the zero-length FINISH path, where Pracuje pulses for exactly 1 cycle before DONE rises.

Counter rules:
- n is W_PROBEK bits and k is W_WSP bits. Neither ever exceeds P_r-1 or N_r-1.
- n-k is computed W_PROBEK+1 bits wide; its sign bit drives zero_probka.

Test Plan:
- N=3, P=4, LAT=2: 24 cycles busy plus FINISH.
  - wr_wyn pulses at adr_wyn 0,1,2,3, 6 cycles apart.
  - For n=1 the issued taps are adr_probki 1,0,0 with zero_probka 0,0,1.
  - mac_first is seen on the first mac_en of each sample.
- Ile_wsp=0, P=1024, Start rises → Pracuje high 1 cycle, DONE=1. No wr_wyn and no mac_en ever.
- N=45, P=1 → exactly 45 mac_en cycles. Taps k >= 1 have zero_probka=1. A single wr_wyn with adr_wyn=0.
- Mid-run, drop Start, raise it again, and change Ile_wsp → the run completes with the latched values and no restart. DONE is set once.
- rst_n low for 1 ns during ISSUE (asynchronous, between clock edges) → all outputs 0 immediately. After release, the next Start rise produces a complete, correct run.
- After a completed run (DONE=1), raise Start again → DONE falls and Pracuje rises on the same edge, and the second run repeats the first run's timing exactly.
